// File: rtl/game_speed_scheduler.sv
// -----------------------------------------------------------------------------
// game_speed_scheduler
//
// Purpose:
//   Sequences the obstacle datapath. Turns the 60 Hz game tick into obstacle
//   move pulses whose cadence speeds up as the BCD score's hundreds digit
//   advances. Also paces spawn requests to the obstacle generator with a
//   randomized gap, counted in move pulses. Everything runs on the pixel clock.
//
// Ports:
//   clk              pixel clock
//   rst              synchronous reset, active-high
//   i_game_tick_60hz one-clk pulse per frame
//   i_game_start     one-clk pulse, game begins
//   i_game_over      one-clk pulse, crash detected
//   i_score[15:0]    4-digit BCD score, [11:8] = hundreds digit
//   i_rng[7:0]       free-running LFSR value
//   i_spawn_ack      obstacle generator accepted the spawn request
//   o_move_pulse     one-clk pulse: advance obstacles by o_step pixels
//   o_step[1:0]      pixels per move (1 below level 4, 2 from level 4)
//   o_level[2:0]     current speed level (saturates at MAX_LEVEL)
//   o_spawn_req      spawn request, held until acknowledged
//   o_running        high while in the RUN state
//   dbg_state[1:0]   current FSM state (0 IDLE, 1 RUN, 2 FROZEN)
//
// Handshake: o_spawn_req is a level that stays high from the clock after the
// gap expires until the first clock edge that samples i_spawn_ack=1; that edge
// completes the transfer and drops the request on the next clock. i_spawn_ack
// seen while o_spawn_req=0 carries no meaning and is ignored. A game over
// withdraws a pending request without waiting for an acknowledge.
// -----------------------------------------------------------------------------
module game_speed_scheduler #(
  parameter int BASE_PERIOD = 4,
  parameter int MAX_LEVEL   = 7,
  parameter int MIN_GAP     = 24,
  parameter int RNG_BITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_game_tick_60hz,
  input  logic        i_game_start,
  input  logic        i_game_over,
  input  logic [15:0] i_score,
  input  logic [7:0]  i_rng,
  input  logic        i_spawn_ack,
  output logic        o_move_pulse,
  output logic [1:0]  o_step,
  output logic [2:0]  o_level,
  output logic        o_spawn_req,
  output logic        o_running,
  output logic [1:0]  dbg_state
);

  // Divider only ever counts up to period-1 <= BASE_PERIOD-1.
  localparam int DIV_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  // Gap counter must hold MIN_GAP + (2**RNG_BITS - 1).
  localparam int GAP_W = $clog2(MIN_GAP + (1 << RNG_BITS));
  localparam logic [2:0] MAX_LVL  = 3'(MAX_LEVEL);
  localparam logic [2:0] FAST_LVL = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [DIV_W-1:0]   divider;
  logic [DIV_W-1:0]   period_m1;
  logic [GAP_W-1:0]   gap;
  logic [GAP_W-1:0]   gap_reload;
  logic [3:0]         hundreds;
  logic [2:0]         level_inc;
  logic               start_run;
  logic               run_active;
  logic               hund_change;

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Next-state logic. Game over beats a simultaneous start; a start while
  // already running is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    run_active = 1'b0;
    case (state)
      IDLE, FROZEN: begin
        if (i_game_start && !i_game_over) begin
          state_next = RUN;
          start_run  = 1'b1;
        end
      end
      RUN: begin
        if (i_game_over) begin
          state_next = FROZEN;
        end else begin
          run_active = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Move period minus one: BASE_PERIOD - level, never below 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    period_m1 = '0;
    if (int'(o_level) < BASE_PERIOD - 1) begin
      period_m1 = DIV_W'(BASE_PERIOD - 1 - int'(o_level));
    end
  end

  // ---------------------------------------------------------------------------
  // Level ramp helpers. Any change of the hundreds digit (including 9->0)
  // bumps the level once.
  // ---------------------------------------------------------------------------
  always_comb begin
    hund_change = run_active && (i_score[11:8] != hundreds);
    level_inc   = o_level;
    if (o_level < MAX_LVL) begin
      level_inc = o_level + 3'd1;
    end
  end

  assign gap_reload = GAP_W'(MIN_GAP) + GAP_W'(i_rng[RNG_BITS-1:0]);

  // ---------------------------------------------------------------------------
  // State register and datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_running    <= 1'b0;
      o_move_pulse <= 1'b0;
      o_step       <= 2'd1;
      o_level      <= 3'd0;
      o_spawn_req  <= 1'b0;
      divider      <= '0;
      gap          <= GAP_W'(MIN_GAP);
      hundreds     <= 4'd0;
    end else begin
      state        <= state_next;
      o_running    <= (state_next == RUN);
      o_move_pulse <= 1'b0;

      if (start_run) begin
        o_level     <= 3'd0;
        o_step      <= 2'd1;
        divider     <= '0;
        hundreds    <= 4'd0;
        gap         <= gap_reload;
        o_spawn_req <= 1'b0;
      end else if (run_active) begin
        // Tick divider. Using >= means a level increase that shrinks the
        // period below the current count fires on the next tick instead of
        // wrapping the counter.
        if (i_game_tick_60hz) begin
          if (divider >= period_m1) begin
            divider      <= '0;
            o_move_pulse <= 1'b1;
          end else begin
            divider <= divider + DIV_W'(1);
          end
        end

        if (hund_change) begin
          hundreds <= i_score[11:8];
          o_level  <= level_inc;
          o_step   <= (level_inc >= FAST_LVL) ? 2'd2 : 2'd1;
        end

        // Spawn gap. The counter is frozen while a request is pending. The
        // request is raised on the clock right after the move pulse that
        // consumes the last gap unit.
        if (o_spawn_req) begin
          if (i_spawn_ack) begin
            o_spawn_req <= 1'b0;
            gap         <= gap_reload;
          end
        end else if (o_move_pulse) begin
          if (gap <= GAP_W'(1)) begin
            gap         <= '0;
            o_spawn_req <= 1'b1;
          end else begin
            gap <= gap - GAP_W'(1);
          end
        end else if (gap == '0) begin
          o_spawn_req <= 1'b1;
        end
      end else begin
        // IDLE, FROZEN, or the game-over cycle: outputs hold, except that a
        // pending request is withdrawn.
        o_spawn_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_speed_scheduler.sv
// -----------------------------------------------------------------------------
// tb_game_speed_scheduler
//
// Directed bench for game_speed_scheduler. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point, so each value read
// reflects the most recent clock edge.
// -----------------------------------------------------------------------------
module tb_game_speed_scheduler;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_game_tick_60hz = 1'b0;
  logic        i_game_start = 1'b0;
  logic        i_game_over = 1'b0;
  logic [15:0] i_score = 16'h0000;
  logic [7:0]  i_rng = 8'h00;
  logic        i_spawn_ack = 1'b0;
  logic        o_move_pulse;
  logic [1:0]  o_step;
  logic [2:0]  o_level;
  logic        o_spawn_req;
  logic        o_running;
  logic [1:0]  dbg_state;

  localparam int ST_IDLE   = 0;
  localparam int ST_RUN    = 1;
  localparam int ST_FROZEN = 2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_speed_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .i_game_tick_60hz (i_game_tick_60hz),
    .i_game_start     (i_game_start),
    .i_game_over      (i_game_over),
    .i_score          (i_score),
    .i_rng            (i_rng),
    .i_spawn_ack      (i_spawn_ack),
    .o_move_pulse     (o_move_pulse),
    .o_step           (o_step),
    .o_level          (o_level),
    .o_spawn_req      (o_spawn_req),
    .o_running        (o_running),
    .dbg_state        (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tick followed by one idle clock. p = pulse in the clock after the
  // tick, r1 = request in that clock, p2/r2 = pulse/request one clock later.
  task automatic tick(output logic p, output logic r1, output logic p2, output logic r2);
    i_game_tick_60hz = 1'b1;
    cyc();
    i_game_tick_60hz = 1'b0;
    p  = o_move_pulse;
    r1 = o_spawn_req;
    cyc();
    p2 = o_move_pulse;
    r2 = o_spawn_req;
  endtask

  task automatic pulse_start();
    i_game_start = 1'b1;
    cyc();
    i_game_start = 1'b0;
  endtask

  task automatic pulse_over();
    i_game_over = 1'b1;
    cyc();
    i_game_over = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pulse"},   o_move_pulse, 0);
    chk({tag, "_step"},    o_step,       1);
    chk({tag, "_level"},   o_level,      0);
    chk({tag, "_req"},     o_spawn_req,  0);
    chk({tag, "_running"}, o_running,    0);
    chk({tag, "_state"},   dbg_state,    ST_IDLE);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic p, r1, p2, r2;
    int   n_pulse;
    int   exp_lvl;

    // Reset
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check_reset_values("rst0");
    tick(p, r1, p2, r2);
    chk("idle_no_pulse", p, 0);

    // Level-0 cadence: pulses 1 clk after ticks 4, 8, 12, each 1 clk wide.
    i_rng = 8'h03;
    pulse_start();
    chk("start_running", o_running, 1);
    chk("start_state",   dbg_state, ST_RUN);
    chk("start_level",   o_level,   0);
    n_pulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("cad_pulse_t%0d", k), p, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("cad_width_t%0d", k), p2, 0);
      if (p) n_pulse++;
    end
    chk("cad_count", n_pulse, 3);
    chk("cad_step",  o_step,  1);

    // Ramp: hundreds 0 (0x0099) -> 1..9, level saturates at 7.
    i_score = 16'h0099;
    cyc();
    chk("ramp_l0", o_level, 0);
    for (int h = 1; h <= 9; h++) begin
      i_score = {4'h0, 4'(h), 8'h00};
      cyc();
      exp_lvl = (h > 7) ? 7 : h;
      chk($sformatf("ramp_level_h%0d", h), o_level, exp_lvl);
      chk($sformatf("ramp_step_h%0d", h),  o_step, (exp_lvl >= 4) ? 2 : 1);
    end
    for (int k = 1; k <= 3; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("fast_pulse_t%0d", k), p, 1);
    end

    // Start while running is ignored.
    pulse_start();
    chk("restart_ignored_level", o_level, 7);
    chk("restart_ignored_state", dbg_state, ST_RUN);

    // Game over without a request: frozen, level retained.
    pulse_over();
    chk("over_running", o_running, 0);
    chk("over_state",   dbg_state, ST_FROZEN);
    chk("over_level",   o_level,   7);
    chk("over_step",    o_step,    2);
    tick(p, r1, p2, r2);
    chk("frozen_no_pulse", p, 0);

    // Spawn game: gap = 24 + 5 = 29.
    i_score = 16'h0000;
    i_rng   = 8'hF5;
    pulse_start();
    chk("sp_start_level", o_level,   0);
    chk("sp_start_step",  o_step,    1);
    chk("sp_start_state", dbg_state, ST_RUN);
    i_score = 16'h0900;
    cyc();
    chk("sp_lvl1", o_level, 1);
    i_score = 16'h1000;            // 9 -> 0 wrap still counts
    cyc();
    chk("sp_lvl2_wrap", o_level, 2);
    i_score = 16'h1100;
    cyc();
    chk("sp_lvl3", o_level, 3);
    for (int k = 1; k <= 29; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("sp_pulse_m%0d", k), p, 1);
      chk($sformatf("sp_req_m%0d", k), r2, (k == 29) ? 1 : 0);
      if (k == 29) chk("sp_req_not_early", r1, 0);
    end

    // Ack withheld: request holds, moves continue.
    for (int k = 1; k <= 10; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("hold_pulse_t%0d", k), p, 1);
      chk($sformatf("hold_req_t%0d", k), r2, 1);
    end

    // Ack with rng[3:0]=0 -> gap 24.
    i_rng       = 8'h30;
    i_spawn_ack = 1'b1;
    cyc();
    i_spawn_ack = 1'b0;
    chk("ack_req_low", o_spawn_req, 0);
    for (int k = 1; k <= 10; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("gap2_req_m%0d", k), r2, 0);
    end
    // Ack while no request pending must not reload the gap.
    i_rng       = 8'h0F;
    i_spawn_ack = 1'b1;
    cyc();
    i_spawn_ack = 1'b0;
    chk("stray_ack_req", o_spawn_req, 0);
    for (int k = 11; k <= 24; k++) begin
      tick(p, r1, p2, r2);
      chk($sformatf("gap2_req_m%0d", k), r2, (k == 24) ? 1 : 0);
    end

    // Game over with request pending.
    pulse_over();
    chk("frz_req",     o_spawn_req, 0);
    chk("frz_running", o_running,   0);
    chk("frz_state",   dbg_state,   ST_FROZEN);
    chk("frz_level",   o_level,     3);
    tick(p, r1, p2, r2);
    chk("frz_no_pulse", p, 0);
    chk("frz_no_req",   r2, 0);

    // Restart from FROZEN: gap = 24 + 2 = 26, ramp to level 3.
    i_score = 16'h0000;
    i_rng   = 8'h02;
    pulse_start();
    chk("rs_level",   o_level,   0);
    chk("rs_running", o_running, 1);
    chk("rs_req",     o_spawn_req, 0);
    for (int h = 1; h <= 3; h++) begin
      i_score = {4'h0, 4'(h), 8'h00};
      cyc();
    end
    chk("rs_lvl3", o_level, 3);
    for (int k = 1; k <= 26; k++) begin
      tick(p, r1, p2, r2);
      if (k >= 25) chk($sformatf("rs_req_m%0d", k), r2, (k == 26) ? 1 : 0);
    end

    // Reset mid-run with request pending.
    rst = 1'b1;
    cyc();
    check_reset_values("rst_mid1");
    cyc();
    check_reset_values("rst_mid2");
    rst = 1'b0;
    tick(p, r1, p2, r2);
    chk("rst_mid_no_pulse", p, 0);
    chk("rst_mid_state",    dbg_state, ST_IDLE);

    // Simultaneous start + over.
    i_game_start = 1'b1;
    i_game_over  = 1'b1;
    cyc();
    chk("both_idle_state",   dbg_state, ST_IDLE);
    chk("both_idle_running", o_running, 0);
    cyc();
    i_game_over = 1'b0;
    cyc();
    i_game_start = 1'b0;
    chk("start_after_both", dbg_state, ST_RUN);
    i_game_start = 1'b1;
    i_game_over  = 1'b1;
    cyc();
    chk("both_run_state",   dbg_state, ST_FROZEN);
    chk("both_run_running", o_running, 0);
    cyc();
    chk("both_frozen_state", dbg_state, ST_FROZEN);
    i_game_start = 1'b0;
    i_game_over  = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
